// File: rtl/usb_tx_pkg.sv
// Shared definitions for the USB TX line blocks: FSM state encoding, bus line levels, defaults.
package usb_tx_pkg;

  localparam int unsigned STUFF_LEN_DEFAULT    = 6;
  localparam int unsigned EOP_SE0_BITS_DEFAULT = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DATA    = 3'd1,
    ST_STUFF   = 3'd2,
    ST_EOP_SE0 = 3'd3,
    ST_EOP_J   = 3'd4
  } tx_state_e;

  // Line levels packed as {dplus, dminus}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

endpackage

// File: rtl/usb_tx_bitstuff_nrzi_if.sv
// Bit-level link between the upstream shifter/counter (master) and the TX line encoder (slave).
interface usb_tx_bitstuff_nrzi_if;

  logic clk12;
  logic tx_bit;
  logic tx_active;
  logic halt;
  logic dplus;
  logic dminus;
  logic eop_done;

  modport master (
    output clk12, tx_bit, tx_active,
    input  halt, dplus, dminus, eop_done
  );

  modport slave (
    input  clk12, tx_bit, tx_active,
    output halt, dplus, dminus, eop_done
  );

endinterface

// File: rtl/usb_tx_nrzi_enc.sv
// NRZI line register (1 = J) and mapping of the current line state onto D+/D-.
module usb_tx_nrzi_enc
  import usb_tx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic toggle_i,
  input  logic force_j_i,
  input  logic se0_i,
  input  logic drive_j_i,
  output logic dplus_o,
  output logic dminus_o
);

  logic       line_j_q;
  logic       line_j_d;
  logic [1:0] line_state;

  always_comb begin
    line_j_d = line_j_q;
    if (force_j_i) begin
      line_j_d = 1'b1;
    end else if (toggle_i) begin
      line_j_d = ~line_j_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_j_q <= 1'b1;
    end else begin
      line_j_q <= line_j_d;
    end
  end

  // SE0 overrides everything; EOP_J drives J whatever the register holds
  always_comb begin
    if (se0_i) begin
      line_state = LINE_SE0;
    end else if (drive_j_i || line_j_q) begin
      line_state = LINE_J;
    end else begin
      line_state = LINE_K;
    end
  end

  assign {dplus_o, dminus_o} = line_state;

endmodule

// File: rtl/usb_tx_bitstuff_nrzi.sv
// USB TX back end: bit stuffing, NRZI encoding and EOP (SE0 + J) generation, advanced on clk12 strobes.
// Stuffing exists only when USB_TX_BITSTUFF_EN is defined; otherwise raw NRZI (test mode), halt tied low.
module usb_tx_bitstuff_nrzi
  import usb_tx_pkg::*;
#(
  parameter int unsigned STUFF_LEN    = STUFF_LEN_DEFAULT,
  parameter int unsigned EOP_SE0_BITS = EOP_SE0_BITS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  usb_tx_bitstuff_nrzi_if.slave tx_if
);

  localparam int unsigned      SE0_W    = $clog2(EOP_SE0_BITS + 1);
  localparam logic [SE0_W-1:0] SE0_LAST = SE0_W'(EOP_SE0_BITS - 1);

  if (STUFF_LEN < 1 || EOP_SE0_BITS < 1) begin : g_bad_params
    $error("usb_tx_bitstuff_nrzi: STUFF_LEN and EOP_SE0_BITS must be at least 1");
  end

  tx_state_e        state_q;
  tx_state_e        state_d;
  logic [SE0_W-1:0] se0_cnt_q;
  logic [SE0_W-1:0] se0_cnt_d;
  logic             eop_done_q;
  logic             eop_done_d;
  logic             encode;
  logic             line_toggle;
  logic             line_force_j;
  logic             line_se0;
  logic             line_drive_j;

`ifdef USB_TX_BITSTUFF_EN
  localparam int unsigned       ONES_W    = $clog2(STUFF_LEN + 1);
  localparam logic [ONES_W-1:0] ONES_FULL = ONES_W'(STUFF_LEN);

  logic [ONES_W-1:0] ones_cnt_q;
  logic [ONES_W-1:0] ones_cnt_d;
`endif

  // A bit from upstream is consumed only in IDLE (first bit) and DATA while the packet is active
  assign encode = tx_if.tx_active && ((state_q == ST_IDLE) || (state_q == ST_DATA));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      se0_cnt_q  <= '0;
      eop_done_q <= 1'b0;
    end else begin
      eop_done_q <= eop_done_d;
      if (tx_if.clk12) begin
        state_q   <= state_d;
        se0_cnt_q <= se0_cnt_d;
      end
    end
  end

`ifdef USB_TX_BITSTUFF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ones_cnt_q <= '0;
    end else if (tx_if.clk12) begin
      ones_cnt_q <= ones_cnt_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    se0_cnt_d = se0_cnt_q;
`ifdef USB_TX_BITSTUFF_EN
    ones_cnt_d = ones_cnt_q;
`endif
    case (state_q)
      ST_IDLE:    if (tx_if.tx_active) state_d = ST_DATA;
      ST_DATA:    if (!tx_if.tx_active) state_d = ST_EOP_SE0;
`ifdef USB_TX_BITSTUFF_EN
      ST_STUFF: begin
        ones_cnt_d = '0;
        state_d    = tx_if.tx_active ? ST_DATA : ST_EOP_SE0;
      end
`endif
      ST_EOP_SE0: begin
        if (se0_cnt_q == SE0_LAST) begin
          se0_cnt_d = '0;
          state_d   = ST_EOP_J;
        end else begin
          se0_cnt_d = se0_cnt_q + SE0_W'(1);
        end
      end
      ST_EOP_J:   state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
`ifdef USB_TX_BITSTUFF_EN
    // Reaching the run limit wins over tx_active: the stuffed bit always goes out
    if (encode) begin
      if (!tx_if.tx_bit) begin
        ones_cnt_d = '0;
      end else begin
        ones_cnt_d = ones_cnt_q + ONES_W'(1);
        if (ones_cnt_q == ONES_FULL - ONES_W'(1)) begin
          state_d = ST_STUFF;
        end
      end
    end
`endif
  end

  always_comb begin
    line_toggle  = 1'b0;
    line_force_j = 1'b0;
    eop_done_d   = 1'b0;
    line_se0     = (state_q == ST_EOP_SE0);
    line_drive_j = (state_q == ST_EOP_J);
    if (tx_if.clk12) begin
      if (encode && !tx_if.tx_bit) begin
        line_toggle = 1'b1;
      end
`ifdef USB_TX_BITSTUFF_EN
      if (state_q == ST_STUFF) begin
        line_toggle = 1'b1;
      end
`endif
      if (state_q == ST_EOP_J) begin
        line_force_j = 1'b1;
        eop_done_d   = 1'b1;
      end
    end
  end

`ifdef USB_TX_BITSTUFF_EN
  assign tx_if.halt = (state_q == ST_STUFF);
`else
  assign tx_if.halt = 1'b0;
`endif
  assign tx_if.eop_done = eop_done_q;

  usb_tx_nrzi_enc u_nrzi_enc (
    .clk       (clk),
    .rst       (rst),
    .toggle_i  (line_toggle),
    .force_j_i (line_force_j),
    .se0_i     (line_se0),
    .drive_j_i (line_drive_j),
    .dplus_o   (tx_if.dplus),
    .dminus_o  (tx_if.dminus)
  );

endmodule

// File: tb/tb_usb_tx_bitstuff_nrzi.sv
// Scoreboard bench for usb_tx_bitstuff_nrzi: directed bit vectors push expected line/halt/eop per strobe,
// a monitor compares after every clk12 strobe. Expectations follow USB_TX_BITSTUFF_EN when defined.
module tb_usb_tx_bitstuff_nrzi;
  import usb_tx_pkg::*;

  typedef struct packed {
    logic       act;
    logic       b;
    logic [1:0] line;
    logic       halt;
    logic       eop;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  int   stray_eop = 0;
  vec_t exp_q[$];

  usb_tx_bitstuff_nrzi_if ifc();

  usb_tx_bitstuff_nrzi #(
    .STUFF_LEN    (6),
    .EOP_SE0_BITS (2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .tx_if (ifc)
  );

  always #5 clk = ~clk;

  function automatic vec_t vec(input logic a, input logic b, input logic [1:0] l,
                               input logic h, input logic e);
    vec_t v;
    v.act = a; v.b = b; v.line = l; v.halt = h; v.eop = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic strobe(input vec_t v);
    exp_q.push_back(v);
    @(negedge clk);
    ifc.tx_active = v.act;
    ifc.tx_bit    = v.b;
    ifc.clk12     = 1'b1;
    @(negedge clk);
    ifc.clk12 = 1'b0;
    @(negedge clk);
  endtask

  task automatic strobe_n(input int n, input vec_t v);
    for (int i = 0; i < n; i++) strobe(v);
  endtask

  // Monitor: one scoreboard pop per strobe edge taken outside reset
  initial begin
    logic strobed;
    vec_t v;
    forever begin
      @(posedge clk);
      strobed = ifc.clk12 && !rst;
      @(negedge clk);
      if (strobed) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL scoreboard: strobe with no expected entry (t=%0t)", $time);
        end else begin
          v = exp_q.pop_front();
          $display("strobe act=%0b bit=%0b line=%b/%b halt=%0b eop=%0b", v.act, v.b,
                   {ifc.dplus, ifc.dminus}, v.line, ifc.halt, ifc.eop_done);
          check("line", {2'b0, ifc.dplus, ifc.dminus}, {2'b0, v.line});
          check("halt", {3'b0, ifc.halt}, {3'b0, v.halt});
          check("eop_done", {3'b0, ifc.eop_done}, {3'b0, v.eop});
        end
      end else if (!rst && ifc.eop_done === 1'b1) begin
        stray_eop++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.clk12     = 1'b0;
    ifc.tx_bit    = 1'b0;
    ifc.tx_active = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_dplus", {3'b0, ifc.dplus}, 4'd1);
    check("rst_dminus", {3'b0, ifc.dminus}, 4'd0);
    check("rst_halt", {3'b0, ifc.halt}, 4'd0);
    check("rst_eop", {3'b0, ifc.eop_done}, 4'd0);
    repeat (5) @(negedge clk);
    check("idle_line", {2'b0, ifc.dplus, ifc.dminus}, {2'b0, LINE_J});

    // SYNC pattern
    strobe_n(1, vec(1, 0, LINE_K, 0, 0));
    strobe_n(1, vec(1, 0, LINE_J, 0, 0));
    strobe_n(1, vec(1, 0, LINE_K, 0, 0));
    strobe_n(1, vec(1, 0, LINE_J, 0, 0));
    strobe_n(1, vec(1, 0, LINE_K, 0, 0));
    strobe_n(1, vec(1, 0, LINE_J, 0, 0));
    strobe_n(1, vec(1, 0, LINE_K, 0, 0));
    strobe_n(1, vec(1, 1, LINE_K, 0, 0));
    // 0 then seven 1s, then 0
    strobe_n(1, vec(1, 0, LINE_J, 0, 0));
`ifdef USB_TX_BITSTUFF_EN
    strobe_n(5, vec(1, 1, LINE_J, 0, 0));
    strobe_n(1, vec(1, 1, LINE_J, 1, 0));
    strobe_n(1, vec(1, 1, LINE_K, 0, 0));
    strobe_n(1, vec(1, 1, LINE_K, 0, 0));
    strobe_n(1, vec(1, 0, LINE_J, 0, 0));
    // last bit is the 6th 1, then EOP (tx_active high during EOP is ignored)
    strobe_n(5, vec(1, 1, LINE_J, 0, 0));
    strobe_n(1, vec(1, 1, LINE_J, 1, 0));
    strobe_n(1, vec(0, 1, LINE_SE0, 0, 0));
`else
    strobe_n(7, vec(1, 1, LINE_J, 0, 0));
    strobe_n(1, vec(1, 0, LINE_K, 0, 0));
    strobe_n(6, vec(1, 1, LINE_K, 0, 0));
    strobe_n(1, vec(0, 1, LINE_SE0, 0, 0));
`endif
    strobe_n(1, vec(1, 0, LINE_SE0, 0, 0));
    strobe_n(1, vec(1, 0, LINE_J, 0, 0));
    strobe_n(1, vec(1, 0, LINE_J, 0, 1));
    strobe_n(1, vec(0, 0, LINE_J, 0, 0));

    // Second packet, with a 10-cycle strobe gap in the middle
    strobe_n(1, vec(1, 1, LINE_J, 0, 0));
    strobe_n(1, vec(1, 0, LINE_K, 0, 0));
    strobe_n(1, vec(1, 0, LINE_J, 0, 0));
    strobe_n(1, vec(1, 1, LINE_J, 0, 0));
    strobe_n(1, vec(1, 0, LINE_K, 0, 0));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ifc.tx_bit    = i[0];
      ifc.tx_active = i[1];
      check("stall_line", {2'b0, ifc.dplus, ifc.dminus}, {2'b0, LINE_K});
    end
    check("stall_halt", {3'b0, ifc.halt}, 4'd0);
    strobe_n(1, vec(1, 0, LINE_J, 0, 0));
    strobe_n(1, vec(1, 1, LINE_J, 0, 0));
    strobe_n(1, vec(1, 0, LINE_K, 0, 0));

    // Reset mid-packet with the line at K, strobe present
    @(negedge clk);
    rst           = 1'b1;
    ifc.clk12     = 1'b1;
    ifc.tx_active = 1'b1;
    ifc.tx_bit    = 1'b0;
    @(negedge clk);
    rst       = 1'b0;
    ifc.clk12 = 1'b0;
    check("abort_line", {2'b0, ifc.dplus, ifc.dminus}, {2'b0, LINE_J});
    check("abort_halt", {3'b0, ifc.halt}, 4'd0);
    check("abort_eop", {3'b0, ifc.eop_done}, 4'd0);
    strobe_n(3, vec(0, 0, LINE_J, 0, 0));
    strobe_n(1, vec(0, 1, LINE_J, 0, 0));

    repeat (4) @(negedge clk);
    check("queue_empty", 4'(exp_q.size()), 4'd0);
    check("stray_eop", 4'(stray_eop), 4'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/usb_tx_bitstuff_nrzi.md
USB_TX_BITSTUFF_NRZI -- requirements
Module: usb_tx_bitstuff_nrzi

Interface
REQ-001 Parameter STUFF_LEN, default 6: number of consecutive 1 bits that forces a stuffed 0.
REQ-002 Parameter EOP_SE0_BITS, default 2: EOP SE0 duration in bit times.
REQ-003 clk  in  1  system clock; the only clock.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 clk12  in  1  one-cycle bit-time strobe; all state advances only on cycles where clk12=1.
REQ-006 tx_bit  in  1  current serial bit (NRZ) from the upstream shift register and bit counter.
REQ-007 tx_active  in  1  high while SYNC/PID/data/CRC bits are presented; low after the final bit.
REQ-008 halt  out  1  tells the upstream counter and shifter to hold the current bit.
REQ-009 dplus  out  1  D+ line drive.
REQ-010 dminus  out  1  D- line drive.
REQ-011 eop_done  out  1  one-cycle pulse on return to idle after EOP.

Function
REQ-012 States SHALL be IDLE, DATA, STUFF, EOP_SE0, EOP_J; transitions SHALL occur only on clk12=1 cycles, otherwise all registers hold.
REQ-013 Line register line_j (1=J): in IDLE, DATA and STUFF, dplus=line_j and dminus=~line_j; in EOP_SE0, dplus=dminus=0; in EOP_J, J is driven.
REQ-014 IDLE: drive J; with clk12 and tx_active=1, go to DATA and encode tx_bit in that same strobe.
REQ-015 DATA encode per strobe: tx_bit=0 toggles line_j and clears ones_cnt; tx_bit=1 holds line_j and increments ones_cnt.
REQ-016 If ones_cnt becomes STUFF_LEN on a strobe, next state SHALL be STUFF, regardless of tx_active.
REQ-017 halt SHALL equal (state==STUFF), combinationally, so upstream ignores exactly one strobe.
REQ-018 STUFF, on strobe: toggle line_j, clear ones_cnt; go to DATA if tx_active=1, else EOP_SE0.
REQ-019 DATA with tx_active=0 on strobe (no pending stuff): go to EOP_SE0 without encoding tx_bit.
REQ-020 EOP_SE0 SHALL last exactly EOP_SE0_BITS strobes (counter of width $clog2(EOP_SE0_BITS+1)), then go to EOP_J.
REQ-021 EOP_J lasts one strobe; on leaving it, set line_j=1, go to IDLE, and pulse eop_done for one clk cycle.
REQ-022 tx_active rising during EOP_SE0 or EOP_J SHALL be ignored until IDLE is reached.
REQ-023 ones_cnt width SHALL be $clog2(STUFF_LEN+1); it SHALL never exceed STUFF_LEN.

Reset
REQ-024 rst=1 SHALL, at the next clk edge and regardless of clk12: state=IDLE, line_j=1 (J), ones_cnt=0, SE0 count=0, halt=0, eop_done=0.
REQ-025 Reset mid-packet SHALL abort without EOP; rst has priority over every other input.

Configuration
REQ-026 Macro USB_TX_BITSTUFF_EN defined: stuffing per REQ-016..018.
REQ-027 Macro undefined: STUFF state and ones_cnt are removed, halt is tied to 0, and the NRZI and EOP behaviour is unchanged (test-mode raw encoding).

Structure
REQ-028 Package usb_tx_pkg SHALL hold the state enum, line-state constants (J, K, SE0) and the STUFF_LEN default; other TX blocks share it.
REQ-029 One sub-module is natural: usb_tx_nrzi_enc (line_j register, toggle, dplus/dminus mapping); the FSM and counters stay in the top level.

Verification
REQ-030 Reset, then no strobes: dplus=1, dminus=0, halt=0, eop_done=0.
REQ-031 tx_active=1 with bits 0,0,0,0,0,0,0,1 (SYNC): line K,J,K,J,K,J,K,K; halt never asserted.
REQ-032 Seven 1s after a 0: halt=1 for exactly one strobe after the 6th 1; stuffed toggle on the line; the 7th 1 encoded next; ones_cnt restarts.
REQ-033 Final bit makes the 6th consecutive 1, then tx_active=0: STUFF, then 2 strobes SE0, then 1 strobe J, then eop_done pulse, then IDLE.
REQ-034 rst=1 during DATA with line at K: next edge J, IDLE, no SE0, no eop_done.
REQ-035 clk12 held low for 10 cycles mid-packet: outputs and state unchanged; the next strobe continues the correct sequence.
